seven_seg_scan_decoder: RTL and testbench

Recovers the 16-bit value shown on the multiplexed seven-segment display by watching the `cathode`/`anode` lines that `seven_seg_fsm` drives. It is the receive side of that display interface. It sits in loopback and self-check builds next to `seven_seg_fsm`, and also decodes captured board signals. Each scanned digit is debounced, converted from segment pattern back to a hex nibble, and assembled into a word. A one-cycle strobe marks each complete scan frame.

---
 rtl/seven_seg_scan_decoder_if.sv | 20 ++
 rtl/seven_seg_scan_decoder.sv | 164 ++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_decoder_if.sv
// Scanned seven-segment display bus: segment/digit lines in, recovered word out.
// The display driver side is the master; the scan decoder is the slave.
interface seven_seg_scan_decoder_if;
    logic [6:0]  cathode;
    logic [7:0]  anode;
    logic [15:0] number;
    logic        number_valid;
    logic        frame_err;
    logic        timeout;

    modport master (
        output cathode, anode,
        input  number, number_valid, frame_err, timeout
    );

    modport slave (
        input  cathode, anode,
        output number, number_valid, frame_err, timeout
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Recovers the 16-bit word from multiplexed seven-segment cathode/anode lines:
// debounces each digit, decodes the hex font and assembles frames with a timeout.
module seven_seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic                     clock,
    input logic                     reset,
    seven_seg_scan_decoder_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int FW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    logic [6:0]       cath_q, cath_p;
    logic [7:0]       an_q, an_p;
    state_t           state, nxt_state;
    logic [SW-1:0]    stab_cnt, nxt_cnt;
    logic [3:0][3:0]  slot, slot_acc;
    logic [3:0]       seen, seen_acc, idx_oh;
    logic             err, err_acc;
    logic [FW-1:0]    frame_cnt, frame_cnt_inc;
    logic [15:0]      number_r;
    logic             valid_r, ferr_r, tmo_r;

    logic             qual, changed, accept, complete, tmo;
    logic [1:0]       idx;
    logic [4:0]       dec;

    function automatic logic [4:0] seg_decode(input logic [6:0] c);
        case (c)
            7'h01:   seg_decode = 5'h10;
            7'h4F:   seg_decode = 5'h11;
            7'h12:   seg_decode = 5'h12;
            7'h06:   seg_decode = 5'h13;
            7'h4C:   seg_decode = 5'h14;
            7'h24:   seg_decode = 5'h15;
            7'h20:   seg_decode = 5'h16;
            7'h0F:   seg_decode = 5'h17;
            7'h00:   seg_decode = 5'h18;
            7'h04:   seg_decode = 5'h19;
            7'h08:   seg_decode = 5'h1A;
            7'h60:   seg_decode = 5'h1B;
            7'h31:   seg_decode = 5'h1C;
            7'h42:   seg_decode = 5'h1D;
            7'h30:   seg_decode = 5'h1E;
            7'h38:   seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    // Only a single active digit in the low four positions counts as a sample.
    always_comb begin
        qual = 1'b0;
        idx  = 2'd0;
        if (an_q[7:4] == 4'hF) begin
            case (an_q[3:0])
                4'hE: begin qual = 1'b1; idx = 2'd0; end
                4'hD: begin qual = 1'b1; idx = 2'd1; end
                4'hB: begin qual = 1'b1; idx = 2'd2; end
                4'h7: begin qual = 1'b1; idx = 2'd3; end
                default: ;
            endcase
        end
    end

    assign changed = {an_q, cath_q} != {an_p, cath_p};
    assign dec     = seg_decode(cath_q);
    assign idx_oh  = 4'b0001 << idx;

    // Any fresh qualifying pair restarts the stability count; with a one-cycle
    // stability window it is accepted on the spot.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = stab_cnt;
        accept    = 1'b0;
        if (state == IDLE || changed) begin
            if (qual) begin
                nxt_cnt = SW'(1);
                if (STABLE_CYCLES == 1) begin
                    accept    = 1'b1;
                    nxt_state = HOLD;
                end else begin
                    nxt_state = SETTLE;
                end
            end else begin
                nxt_state = IDLE;
            end
        end else if (state == SETTLE) begin
            if (stab_cnt + SW'(1) == SW'(STABLE_CYCLES)) begin
                accept    = 1'b1;
                nxt_state = HOLD;
            end else begin
                nxt_cnt = stab_cnt + SW'(1);
            end
        end
    end

    always_comb begin
        slot_acc = slot;
        seen_acc = seen;
        err_acc  = err;
        if (accept) begin
            slot_acc[idx] = dec[3:0];
            seen_acc      = seen | idx_oh;
            err_acc       = err | ~dec[4];
        end
    end

    assign complete      = accept && (seen_acc == 4'hF);
    assign frame_cnt_inc = frame_cnt + FW'(1);
    assign tmo           = !complete && (seen != 4'h0) && (frame_cnt_inc == FW'(TIMEOUT_CYCLES));

    always_ff @(posedge clock) begin
        if (reset) begin
            cath_q    <= 7'h00;
            an_q      <= 8'hFF;
            cath_p    <= 7'h00;
            an_p      <= 8'hFF;
            state     <= IDLE;
            stab_cnt  <= '0;
            slot      <= '0;
            seen      <= 4'h0;
            err       <= 1'b0;
            frame_cnt <= '0;
            number_r  <= 16'h0000;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            tmo_r     <= 1'b0;
        end else begin
            cath_q   <= bus.cathode;
            an_q     <= bus.anode;
            cath_p   <= cath_q;
            an_p     <= an_q;
            state    <= nxt_state;
            stab_cnt <= nxt_cnt;
            valid_r  <= complete;
            ferr_r   <= complete & err_acc;
            tmo_r    <= tmo;
            slot     <= slot_acc;
            if (complete) begin
                number_r  <= slot_acc;
                seen      <= 4'h0;
                err       <= 1'b0;
                frame_cnt <= '0;
            end else if (tmo) begin
                // An abandoned frame drops everything, including a digit landing this cycle.
                seen      <= 4'h0;
                err       <= 1'b0;
                frame_cnt <= '0;
            end else begin
                seen      <= seen_acc;
                err       <= err_acc;
                frame_cnt <= (seen != 4'h0) ? frame_cnt_inc : '0;
            end
        end
    end

    assign bus.number       = number_r;
    assign bus.number_valid = valid_r;
    assign bus.frame_err    = ferr_r;
    assign bus.timeout      = tmo_r;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: frames pushed to a scoreboard as
// they are driven and compared when number_valid strobes.
module tb_seven_seg_scan_decoder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   tmo_seen = 0;

    typedef struct packed {
        logic [15:0] num;
        logic        ferr;
    } exp_t;
    exp_t exp_q[$];

    seven_seg_scan_decoder_if bus();

    seven_seg_scan_decoder #(.STABLE_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [7:0] an, input logic [6:0] ca, input int n);
        @(negedge clock);
        bus.anode   = an;
        bus.cathode = ca;
        repeat (n - 1) @(negedge clock);
    endtask

    task automatic digit(input int i, input logic [6:0] ca, input int n);
        logic [7:0] an;
        an = ~(8'h01 << i);
        drive(an, ca, n);
    endtask

    // Scoreboard side: every strobe must match the oldest outstanding frame.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.number_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {16'h0, bus.number}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("number", {16'h0, bus.number}, {16'h0, e.num});
                    chk("frame_err", {31'h0, bus.frame_err}, {31'h0, e.ferr});
                end
            end
            if (bus.timeout) tmo_seen++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int pulses;
        bus.anode   = 8'hFF;
        bus.cathode = 7'h7F;
        reset       = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_number", {16'h0, bus.number}, 32'h0);
        chk("rst_valid", {31'h0, bus.number_valid}, 32'h0);
        chk("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
        chk("rst_timeout", {31'h0, bus.timeout}, 32'h0);
        reset = 1'b0;
        drive(8'hFF, 7'h7F, 2);

        // 4321 with exact strobe latency on the last digit
        digit(0, 7'h4F, 3);
        digit(1, 7'h12, 3);
        digit(2, 7'h06, 3);
        exp_q.push_back('{num: 16'h4321, ferr: 1'b0});
        @(negedge clock);
        bus.anode = 8'hF7; bus.cathode = 7'h4C;
        @(negedge clock);
        chk("lat_edge_k", {31'h0, bus.number_valid}, 32'h0);
        @(negedge clock);
        chk("lat_edge_k1", {31'h0, bus.number_valid}, 32'h0);
        @(negedge clock);
        chk("lat_edge_k2", {31'h0, bus.number_valid}, 32'h1);
        @(negedge clock);
        chk("lat_single_pulse", {31'h0, bus.number_valid}, 32'h0);
        drive(8'hFF, 7'h7F, 3);

        // BEEF scanned twice, back to back
        for (int s = 0; s < 2; s++) begin
            exp_q.push_back('{num: 16'hBEEF, ferr: 1'b0});
            digit(0, 7'h38, 3);
            digit(1, 7'h30, 3);
            digit(2, 7'h30, 3);
            digit(3, 7'h60, 3);
        end
        drive(8'hFF, 7'h7F, 3);
        chk("beef_held", {16'h0, bus.number}, 32'hBEEF);

        // one-cycle glitch on digit 0 must not complete the frame early
        digit(1, 7'h24, 3);
        digit(0, 7'h01, 1);
        digit(2, 7'h31, 3);
        digit(3, 7'h42, 3);
        drive(8'hFF, 7'h7F, 2);
        chk("glitch_pending", {16'h0, bus.number}, 32'hBEEF);
        exp_q.push_back('{num: 16'hDC5A, ferr: 1'b0});
        digit(0, 7'h08, 3);
        drive(8'hFF, 7'h7F, 3);

        // undecodable digit 2, then a clean frame
        exp_q.push_back('{num: 16'h1011, ferr: 1'b1});
        digit(0, 7'h4F, 3);
        digit(1, 7'h4F, 3);
        digit(2, 7'h7F, 3);
        digit(3, 7'h4F, 3);
        drive(8'hFF, 7'h7F, 3);
        exp_q.push_back('{num: 16'h3210, ferr: 1'b0});
        digit(0, 7'h01, 3);
        digit(1, 7'h4F, 3);
        digit(2, 7'h12, 3);
        digit(3, 7'h06, 3);
        drive(8'hFF, 7'h7F, 3);

        // partial frame abandoned: accept at edge k+2, timeout at k+18
        first  = 0;
        pulses = 0;
        @(negedge clock);
        bus.anode = 8'hFE; bus.cathode = 7'h01;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clock);
            if (j == 3) begin bus.anode = 8'hFD; bus.cathode = 7'h01; end
            if (j == 6) begin bus.anode = 8'hFF; bus.cathode = 7'h7F; end
            if (bus.timeout) begin
                pulses++;
                if (first == 0) first = j;
            end
        end
        chk("timeout_cycle", first, 19);
        chk("timeout_pulses", pulses, 1);
        chk("timeout_number_kept", {16'h0, bus.number}, 32'h3210);

        // reset mid-frame, then a fresh frame
        digit(0, 7'h01, 3);
        digit(1, 7'h01, 3);
        digit(2, 7'h01, 3);
        @(negedge clock);
        reset = 1'b1;
        bus.anode = 8'hFF; bus.cathode = 7'h7F;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_number", {16'h0, bus.number}, 32'h0);
        chk("midrst_valid", {31'h0, bus.number_valid}, 32'h0);
        chk("midrst_frame_err", {31'h0, bus.frame_err}, 32'h0);
        chk("midrst_timeout", {31'h0, bus.timeout}, 32'h0);
        exp_q.push_back('{num: 16'h1000, ferr: 1'b0});
        digit(0, 7'h01, 3);
        digit(1, 7'h01, 3);
        digit(2, 7'h01, 3);
        digit(3, 7'h4F, 3);
        drive(8'hFF, 7'h7F, 5);

        chk("frames_outstanding", exp_q.size(), 0);
        chk("timeout_total", tmo_seen, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
